// File: rtl/rotate_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rotate_sequencer_pkg : shared constants, state encoding, direction helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rotate_sequencer_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // A right rotate by n is a left rotate by (DATA_W - n) mod DATA_W.
  function automatic logic [AMT_W-1:0] left_amt(input logic [AMT_W-1:0] amt,
                                                input logic             dir);
    left_amt = dir ? ({AMT_W{1'b0}} - amt) : amt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rotate_sequencer_left_shifter.sv
// ---------------------------------------------------------------------------
// left_shifter : combinational left rotator
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module left_shifter
  import rotate_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] y
);

  logic [2*DATA_W-1:0] w_dbl;

  // Bits pushed out of the low copy land in the high copy's LSBs.
  assign w_dbl = {a, a} << amt;
  assign y     = w_dbl[2*DATA_W-1:DATA_W];

endmodule

`default_nettype wire

// File: rtl/rotate_sequencer.sv
// ---------------------------------------------------------------------------
// rotate_sequencer : handshaked burst generator around the left rotator
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rotate_sequencer
  import rotate_sequencer_pkg::*;
#(
  parameter int REPS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_dir,
  input  logic [REPS_W-1:0] in_reps,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  logic [0:0]        state_q,     state_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [REPS_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0]  amt_q,       amt_d;

  logic              w_accept;
  logic              w_beat;
  logic [AMT_W-1:0]  w_amt_eff;
  logic [DATA_W-1:0] w_rot_a;
  logic [AMT_W-1:0]  w_rot_amt;
  logic [DATA_W-1:0] w_rot_y;

  assign out_last  = out_valid_q & (remaining_q == '0);
  // Combinational through out_ready so a new burst follows the last beat with no bubble.
  assign in_ready  = (state_q == ST_IDLE) | (out_last & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_beat    = out_valid_q & out_ready;
  assign w_amt_eff = left_amt(in_amt, in_dir);

  assign w_rot_a   = w_accept ? in_data   : out_data_q;
  assign w_rot_amt = w_accept ? w_amt_eff : amt_q;

  left_shifter u_rot (
    .a   (w_rot_a),
    .amt (w_rot_amt),
    .y   (w_rot_y)
  );

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    remaining_d = remaining_q;
    amt_d       = amt_q;
    if (w_accept) begin
      out_data_d  = w_rot_y;
      remaining_d = in_reps;
      amt_d       = w_amt_eff;
      out_valid_d = 1'b1;
      state_d     = ST_EMIT;
    end else if (w_beat) begin
      if (remaining_q != '0) begin
        out_data_d  = w_rot_y;
        remaining_d = remaining_q - REPS_W'(1);
      end else begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      remaining_q <= '0;
      amt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      remaining_q <= remaining_d;
      amt_q       <= amt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == ST_EMIT);

endmodule

`default_nettype wire

// File: tb/tb_rotate_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rotate_sequencer : directed self-checking bench for rotate_sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rotate_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [2:0] in_amt = 3'd0;
  logic       in_dir = 1'b0;
  logic [3:0] in_reps = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  rotate_sequencer #(.REPS_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_reps   (in_reps),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic request(input logic [7:0] d, input logic [2:0] a,
                         input logic dir, input logic [3:0] r);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    in_reps  = r;
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data",  int'(out_data),  'h00);
    check("rst_ready", int'(in_ready),  1);
    check("rst_busy",  int'(busy),      0);
    check("rst_last",  int'(out_last),  0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single word 0x81 rotl 1.
    request(8'h81, 3'd1, 1'b0, 4'd0);
    step();
    in_valid = 1'b0;
    check("t1_valid", int'(out_valid), 1);
    check("t1_data",  int'(out_data),  'h03);
    check("t1_last",  int'(out_last),  1);
    check("t1_busy",  int'(busy),      1);
    step();
    check("t1_idle_valid", int'(out_valid), 0);
    check("t1_idle_busy",  int'(busy),      0);
    check("t1_idle_ready", int'(in_ready),  1);
    check("t1_hold_data",  int'(out_data),  'h03);

    // Eight-word walking one.
    request(8'h01, 3'd1, 1'b0, 4'd7);
    step();
    in_valid = 1'b0;
    begin
      logic [7:0] exp_w [8];
      exp_w = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t2_data%0d", i), int'(out_data), int'(exp_w[i]));
        check($sformatf("t2_last%0d", i), int'(out_last), (i == 7) ? 1 : 0);
        check($sformatf("t2_valid%0d", i), int'(out_valid), 1);
        step();
      end
    end
    check("t2_end_valid", int'(out_valid), 0);

    // Right rotate by 3, two words.
    request(8'h01, 3'd3, 1'b1, 4'd1);
    step();
    in_valid = 1'b0;
    check("t3_data0", int'(out_data), 'h20);
    check("t3_last0", int'(out_last), 0);
    step();
    check("t3_data1", int'(out_data), 'h04);
    check("t3_last1", int'(out_last), 1);
    step();
    request(8'hA5, 3'd0, 1'b1, 4'd0);
    step();
    in_valid = 1'b0;
    check("t3_r0_data", int'(out_data), 'hA5);
    check("t3_r0_last", int'(out_last), 1);
    step();

    // Back-pressure then back-to-back accept on the last beat.
    out_ready = 1'b0;
    request(8'h01, 3'd1, 1'b0, 4'd2);
    step();
    in_valid = 1'b0;
    check("t4_first", int'(out_data), 'h02);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_hold_data%0d", i), int'(out_data), 'h02);
      check($sformatf("t4_hold_last%0d", i), int'(out_last), 0);
      check($sformatf("t4_hold_rdy%0d", i),  int'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    check("t4_w1", int'(out_data), 'h04);
    check("t4_w1_last", int'(out_last), 0);
    step();
    check("t4_w2", int'(out_data), 'h08);
    check("t4_w2_last", int'(out_last), 1);
    request(8'h0F, 3'd4, 1'b0, 4'd0);
    #1;
    check("t4_b2b_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("t4_b2b_valid", int'(out_valid), 1);
    check("t4_b2b_data",  int'(out_data),  'hF0);
    check("t4_b2b_last",  int'(out_last),  1);
    check("t4_b2b_busy",  int'(busy),      1);
    step();
    check("t4_end_valid", int'(out_valid), 0);

    // Reset during third word of a long burst.
    request(8'h01, 3'd1, 1'b0, 4'd7);
    step();
    in_valid = 1'b0;
    step();
    step();
    check("t5_third", int'(out_data), 'h08);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", int'(out_valid), 0);
    check("t5_rst_last",  int'(out_last),  0);
    check("t5_rst_busy",  int'(busy),      0);
    check("t5_rst_data",  int'(out_data),  'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t5_post_valid", int'(out_valid), 0);
    check("t5_post_ready", int'(in_ready),  1);
    request(8'h81, 3'd1, 1'b0, 4'd0);
    step();
    in_valid = 1'b0;
    check("t5_fresh_data", int'(out_data), 'h03);
    check("t5_fresh_last", int'(out_last), 1);
    step();
    check("t5_fresh_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
